// File: rtl/mc_controller.sv
// Multicycle sequencing controller for the RV32I-subset core: a Moore FSM with a
// memory-ready handshake so that fetch, load and store accesses can stall.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE   | ALUOut <= OldPC + imm (branch target), dispatch on op
// MEMADR   | ALUOut <= A + imm (load/store address)
// MEMREAD  | read data at ALUOut, wait for memory
// MEMWB    | rd <= Data
// MEMWRITE | write B to ALUOut, hold strobe until memory is ready
// EXECR    | ALUOut <= A op B
// EXECI    | ALUOut <= A op imm
// ALUWB    | rd <= ALUOut
// BEQ      | compare A and B, PC <= ALUOut when equal
// JAL      | PC <= ALUOut (target), ALUOut <= OldPC + 4
// TRAP     | unsupported opcode, sticky until reset
module mc_controller #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       Retire,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t     r_state;
    logic       w_op_legal;
    logic [1:0] w_alu_op;
    logic       w_pc_write;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_retire;
    logic       w_illegal;

    always_comb begin
        case (op)
            7'b0000011, 7'b0100011, 7'b0110011,
            7'b0010011, 7'b1100011, 7'b1101111: w_op_legal = 1'b1;
            default:                             w_op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    if (MemReady) r_state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        7'b0000011, 7'b0100011: r_state <= S_MEMADR;
                        7'b0110011:             r_state <= S_EXECR;
                        7'b0010011:             r_state <= S_EXECI;
                        7'b1100011:             r_state <= S_BEQ;
                        7'b1101111:             r_state <= S_JAL;
                        default:                r_state <= TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                    endcase
                end
                S_MEMADR:   r_state <= op[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (MemReady) r_state <= S_MEMWB;
                S_MEMWB:    r_state <= S_FETCH;
                S_MEMWRITE: if (MemReady) r_state <= S_FETCH;
                S_EXECR:    r_state <= S_ALUWB;
                S_EXECI:    r_state <= S_ALUWB;
                S_ALUWB:    r_state <= S_FETCH;
                S_BEQ:      r_state <= S_FETCH;
                S_JAL:      r_state <= S_ALUWB;
                S_TRAP:     r_state <= S_TRAP;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        w_pc_write  = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_retire    = 1'b0;
        w_illegal   = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        w_alu_op    = 2'b00;
        case (r_state)
            S_FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                w_ir_write = MemReady;
                w_pc_write = MemReady;
            end
            S_DECODE: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b01;
                w_retire = !w_op_legal && !TRAP_ON_ILLEGAL;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
                w_retire    = MemReady;
            end
            S_EXECR: begin
                ALUSrcA  = 2'b10;
                w_alu_op = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = 2'b10;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                w_alu_op   = 2'b01;
                w_pc_write = Zero;
                w_retire   = 1'b1;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                w_pc_write = 1'b1;
            end
            S_TRAP:  w_illegal = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        case (op)
            7'b0100011: ImmSrc = 2'b01;
            7'b1100011: ImmSrc = 2'b10;
            7'b1101111: ImmSrc = 2'b11;
            default:    ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        ALUControl = 3'b000;
        case (w_alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
                    3'b001:  ALUControl = 3'b110;
                    3'b010:  ALUControl = 3'b101;
                    3'b100:  ALUControl = 3'b000;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Reset masks every write enable immediately so an aborted access cannot land.
    assign PCWrite  = w_pc_write  & ~reset;
    assign MemWrite = w_mem_write & ~reset;
    assign IRWrite  = w_ir_write  & ~reset;
    assign RegWrite = w_reg_write & ~reset;
    assign Retire   = w_retire    & ~reset;
    assign Illegal  = w_illegal   & ~reset;
    assign State    = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class cycle by cycle
// with hand-computed control values, including memory stalls, traps and resets.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;

    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Retire, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    logic       n_PCWrite, n_AdrSrc, n_MemWrite, n_IRWrite, n_RegWrite, n_Retire, n_Illegal;
    logic [1:0] n_ResultSrc, n_ALUSrcA, n_ALUSrcB, n_ImmSrc;
    logic [2:0] n_ALUControl;
    logic [3:0] n_State;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int retire_cnt = 0;
    int irw_cnt = 0;
    int mw_cnt = 0;
    int t0, r0, i0, m0;

    mc_controller #(.TRAP_ON_ILLEGAL(1'b1)) u_dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .RegWrite(RegWrite), .Retire(Retire),
        .Illegal(Illegal), .State(State)
    );

    mc_controller #(.TRAP_ON_ILLEGAL(1'b0)) u_nop (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(n_PCWrite), .AdrSrc(n_AdrSrc),
        .MemWrite(n_MemWrite), .IRWrite(n_IRWrite), .ResultSrc(n_ResultSrc),
        .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB), .ImmSrc(n_ImmSrc),
        .ALUControl(n_ALUControl), .RegWrite(n_RegWrite), .Retire(n_Retire),
        .Illegal(n_Illegal), .State(n_State)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (Retire)   retire_cnt <= retire_cnt + 1;
        if (IRWrite)  irw_cnt    <= irw_cnt + 1;
        if (MemWrite) mw_cnt     <= mw_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b1; MemReady = 1'b1; Zero = 1'b0;
        op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b0;
        go(2);
        chk("reset_state", State, 0);
        chk("reset_pcwrite", PCWrite, 0);
        chk("reset_irwrite", IRWrite, 0);
        reset = 1'b0; #1;
        chk("fetch_pcwrite", PCWrite, 1);
        chk("fetch_alusrcb", ALUSrcB, 2);

        // addi
        t0 = cyc; r0 = retire_cnt;
        chk("addi_s0_irwrite", IRWrite, 1);
        tick(); chk("addi_s1", State, 1); chk("addi_dec_srca", ALUSrcA, 1);
        tick(); chk("addi_s7", State, 7); chk("addi_aluctl", ALUControl, 0);
        chk("addi_execi_regwrite", RegWrite, 0); chk("addi_immsrc", ImmSrc, 0);
        tick(); chk("addi_s8", State, 8); chk("addi_aluwb_regwrite", RegWrite, 1);
        chk("addi_aluwb_retire", Retire, 1);
        tick(); chk("addi_s0", State, 0);
        chk("addi_cycles", cyc - t0, 4); chk("addi_retires", retire_cnt - r0, 1);

        // sub / add / sll in EXECR
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        go(2); chk("sub_s6", State, 6); chk("sub_aluctl", ALUControl, 1);
        chk("sub_srcb", ALUSrcB, 0);
        go(2); chk("sub_back", State, 0);
        funct7b5 = 1'b0;
        go(2); chk("add_aluctl", ALUControl, 0);
        go(2);
        funct3 = 3'b001;
        go(2); chk("sll_aluctl", ALUControl, 6);
        go(2); chk("sll_back", State, 0);

        // lw with 2 fetch stalls and 3 memread stalls
        op = 7'b0000011; funct3 = 3'b010;
        t0 = cyc; i0 = irw_cnt;
        MemReady = 1'b0; #1;
        chk("lw_stall_irwrite", IRWrite, 0); chk("lw_stall_pcwrite", PCWrite, 0);
        tick(); chk("lw_stall_s0", State, 0);
        tick(); MemReady = 1'b1; #1;
        tick(); chk("lw_s1", State, 1);
        tick(); chk("lw_s2", State, 2); chk("lw_memadr_srca", ALUSrcA, 2);
        tick(); chk("lw_s3", State, 3); chk("lw_adrsrc", AdrSrc, 1);
        MemReady = 1'b0;
        tick(); tick(); chk("lw_still_s3", State, 3);
        tick(); chk("lw_still_s3b", State, 3);
        MemReady = 1'b1;
        tick(); chk("lw_s4", State, 4); chk("lw_resultsrc", ResultSrc, 1);
        chk("lw_regwrite", RegWrite, 1);
        tick(); chk("lw_back", State, 0);
        chk("lw_cycles", cyc - t0, 10); chk("lw_irwrite_cnt", irw_cnt - i0, 1);

        // sw with 2 memwrite stalls
        op = 7'b0100011; funct3 = 3'b010;
        m0 = mw_cnt; r0 = retire_cnt;
        go(3); chk("sw_s5", State, 5);
        MemReady = 1'b0; #1;
        chk("sw_memwrite", MemWrite, 1); chk("sw_adrsrc", AdrSrc, 1);
        chk("sw_immsrc", ImmSrc, 1); chk("sw_noretire", Retire, 0);
        tick(); chk("sw_memwrite2", MemWrite, 1);
        tick(); MemReady = 1'b1; #1;
        chk("sw_memwrite3", MemWrite, 1); chk("sw_retire", Retire, 1);
        tick(); chk("sw_back", State, 0);
        chk("sw_memwrite_cnt", mw_cnt - m0, 3); chk("sw_retires", retire_cnt - r0, 1);

        // beq taken / not taken
        op = 7'b1100011; funct3 = 3'b000; Zero = 1'b1; t0 = cyc;
        go(2); chk("beq_s9", State, 9); chk("beq_taken_pcw", PCWrite, 1);
        chk("beq_aluctl", ALUControl, 1); chk("beq_immsrc", ImmSrc, 2);
        tick(); chk("beq_cycles", cyc - t0, 3); chk("beq_back", State, 0);
        Zero = 1'b0;
        go(2); chk("beq_nt_pcw", PCWrite, 0); chk("beq_nt_retire", Retire, 1);
        tick();

        // jal
        op = 7'b1101111;
        tick(); chk("jal_s1", State, 1);
        tick(); chk("jal_s10", State, 10); chk("jal_pcwrite", PCWrite, 1);
        chk("jal_immsrc", ImmSrc, 3); chk("jal_srca", ALUSrcA, 1);
        tick(); chk("jal_s8", State, 8); chk("jal_regwrite", RegWrite, 1);
        tick(); chk("jal_back", State, 0);

        // illegal opcode, both trap settings
        op = 7'b1111111;
        tick(); chk("ill_s1", State, 1);
        chk("ill_nop_retire", n_Retire, 1); chk("ill_trap_noretire", Retire, 0);
        tick(); chk("ill_s11", State, 11); chk("ill_flag", Illegal, 1);
        chk("ill_nop_back", n_State, 0); chk("ill_nop_flag", n_Illegal, 0);
        go(20); chk("ill_sticky", State, 11); chk("ill_sticky_flag", Illegal, 1);
        chk("ill_pcwrite", PCWrite, 0);
        reset = 1'b1; #1;
        chk("ill_reset_mask", Illegal, 0);
        tick(); chk("ill_reset_state", State, 0);
        reset = 1'b0;

        // reset during a stalled store
        op = 7'b0100011; MemReady = 1'b1;
        go(3); MemReady = 1'b0; #1;
        chk("rst_sw_s5", State, 5); chk("rst_sw_memwrite", MemWrite, 1);
        reset = 1'b1; #1;
        chk("rst_sw_mask", MemWrite, 0);
        tick(); chk("rst_sw_state", State, 0);
        reset = 1'b0; MemReady = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle sequencing controller for the RV32I-subset core. It replaces the single-cycle main/ALU decoders with a Moore state machine that steps a shared-memory datapath through fetch, decode, execute, memory and writeback. That datapath has an instruction register, an OldPC register, A/B registers, an ALUOut register and a Data register. The controller adds a memory-ready handshake so that instruction and data memory accesses can stall.

## Interface
- TRAP_ON_ILLEGAL, 1: 1 = an unsupported opcode enters sticky TRAP; 0 = an unsupported opcode retires as a NOP.

- clk  in  1  clock; everything updates on the rising edge.
- reset  in  1  synchronous, active-high.
- op  in  7  Instr[6:0] from the instruction register.
- funct3  in  3  Instr[14:12].
- funct7b5  in  1  Instr[30].
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  load the instruction register and OldPC.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = A register.
- ALUSrcB  out  2  ALU B select: 00 = B register, 01 = ImmExt, 10 = constant 4.
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  out  3  same ALU encoding as the single-cycle core: 000 add, 001 sub, 010 and, 011 or, 101 slt, 110 sll.
- RegWrite  out  1  register file write enable.
- Retire  out  1  one-cycle pulse on the final cycle of each instruction.
- Illegal  out  1  high while in TRAP.
- State  out  4  current state encoding, for debug.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
- Any output not listed for a state is 0.
- FETCH
  - Drives AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCWrite=MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE
  - Drives ALUSrcA=01, ALUSrcB=01, ALUOp=00, which computes the branch target into ALUOut.
  - Next state by op:
    - 0000011 (lw, lbu) and 0100011 (sw) → MEMADR.
    - 0110011 → EXECR.
    - 0010011 → EXECI.
    - 1100011 → BEQ.
    - 1101111 → JAL.
    - any other op → TRAP, or → FETCH with Retire=1 when TRAP_ON_ILLEGAL=0.
- MEMADR
  - Drives ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - Goes to MEMREAD if op[5]=0, otherwise MEMWRITE.
- MEMREAD
  - Drives AdrSrc=1, ResultSrc=00.
  - Waits for MemReady, then goes to MEMWB.
- MEMWB
  - Drives ResultSrc=01, RegWrite=1, Retire=1.
  - Goes to FETCH.
- MEMWRITE
  - Drives AdrSrc=1, ResultSrc=00.
  - MemWrite=1 is held every cycle until MemReady=1.
  - Retire=MemReady; goes to FETCH when MemReady=1.
- EXECR
  - Drives ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - Goes to ALUWB.
- EXECI
  - Drives ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - Goes to ALUWB.
- ALUWB
  - Drives ResultSrc=00, RegWrite=1, Retire=1.
  - Goes to FETCH.
- BEQ
  - Drives ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - PCWrite=Zero, Retire=1.
  - Goes to FETCH.
- JAL
  - Drives ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1.
  - Goes to ALUWB, which writes PC+4 to rd.
- TRAP
  - Illegal=1; all enables are 0.
  - Stays in TRAP until reset.
- ImmSrc is combinational from op in every state:
  - 0100011 → 01.
  - 1100011 → 10.
  - 1101111 → 11.
  - all other ops → 00.
- ALUControl is combinational from ALUOp:
  - ALUOp 00 → 000; ALUOp 01 → 001.
  - ALUOp 10 decodes funct3:
    - 000 → 001 if (funct7b5 & op[5]), else 000.
    - 001 → 110.
    - 010 → 101.
    - 100 → 000.
    - 110 → 011.
    - 111 → 010.
    - any other funct3 → 000.
- ALUOp is internal only.

## Timing
- Reset
  - reset=1 at a rising edge sets State=FETCH.
  - While reset=1, PCWrite, IRWrite, RegWrite, MemWrite, Retire and Illegal are all forced to 0 combinationally.
  - A reset mid-instruction aborts the instruction with no further writes; this includes TRAP and a stalled MEMWRITE.
- Cycles per instruction with MemReady held at 1: lw/lbu 5, sw 4, R-type 4, I-type 4, beq 3, jal 4.
- Each cycle MemReady is low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- MemReady is ignored in every other state.
- Decode inputs (op, funct3, funct7b5) are only sampled from DECODE onward, i.e. after IRWrite.
- Zero is sampled only in BEQ.
- Outputs are Moore functions of State, plus MemReady/Zero gating where stated above; there are no registered outputs beyond State.
- Exactly one Retire pulse is produced per instruction.

## Test plan
- Reset, then MemReady=1 and an addi instruction (op=0010011, funct3=000):
  - State sequence is 0,1,7,8,0.
  - RegWrite=1 only in ALUWB, ALUControl=000 in EXECI.
  - Retire pulses once.
- sub instruction (op=0110011, funct3=000, funct7b5=1):
  - ALUControl=001 in EXECR.
  - The same fields with funct7b5=0 give 000.
  - sll (funct3=001) gives 110.
- lw with MemReady low for the first 2 cycles of FETCH and 3 cycles of MEMREAD:
  - Instruction takes 10 cycles.
  - IRWrite pulses exactly once.
  - MEMWB asserts ResultSrc=01 and RegWrite=1.
- sw with MemReady low for 2 MEMWRITE cycles:
  - MemWrite=1 for 3 consecutive cycles with AdrSrc=1 and ImmSrc=01.
  - Retire rises together with MemReady.
- beq:
  - Zero=1 → PCWrite=1 in BEQ, 3 cycles total.
  - Zero=0 → PCWrite=0.
- jal gives sequence 0,1,10,8 with PCWrite=1 in JAL and ImmSrc=11.
- op=1111111 with TRAP_ON_ILLEGAL=1:
  - State goes to 11, Illegal=1 and stays there for 20 cycles.
  - Reset returns State to 0.
  - With TRAP_ON_ILLEGAL=0, Retire fires in DECODE and State returns to 0.
- reset asserted during a stalled MEMWRITE forces MemWrite=0 in the same cycle and State=0 after the next edge.
